// File: rtl/cb_dina_map_pkg.sv
// Shared codes for the CB port-A mappers and address generator: select fields,
// NL write-back state/step encodings and the lane/bank word containers.
package cb_dina_map_pkg;

   localparam int X              = 4;
   localparam int L              = 4;
   localparam int RSA_DW         = 32;
   localparam int CB_DINA_SEL_DW = 5;

   typedef logic signed [RSA_DW-1:0]     word_t;
   typedef logic [X-1:0][RSA_DW-1:0]     lane_vec_t;
   typedef logic [L-1:0][RSA_DW-1:0]     bank_vec_t;

   typedef enum logic [2:0] {
      CBd_IDLE = 3'b000,
      CBd_C    = 3'b001,
      CBd_NL   = 3'b111
   } cbd_src_e;

   typedef enum logic [1:0] {
      DIR_IDLE = 2'b00,
      DIR_POS  = 2'b01,
      DIR_NEG  = 2'b10,
      DIR_NEW  = 2'b11
   } cbd_dir_e;

   typedef enum logic [1:0] {
      NL_IDLE = 2'd0,
      NL_W_X  = 2'd1,
      NL_W_Y  = 2'd2,
      NL_W_T  = 2'd3
   } nl_state_e;

   typedef enum logic [1:0] {
      NL_STEP_X = 2'd0,
      NL_STEP_Y = 2'd1,
      NL_STEP_T = 2'd2
   } nl_step_e;

   typedef struct packed {
      word_t xk;
      word_t yk;
      word_t xita;
      word_t lkx;
      word_t lky;
   } nl_vals_t;

   function automatic logic [2:0] sel_src(input logic [CB_DINA_SEL_DW-1:0] sel);
      return sel[4:2];
   endfunction

   function automatic cbd_dir_e sel_dir(input logic [CB_DINA_SEL_DW-1:0] sel);
      return cbd_dir_e'(sel[1:0]);
   endfunction

endpackage

// File: rtl/cb_dina_map_if.sv
// CB port-A write-side bundle: select/lane/NL inputs toward the mapper and the
// registered write word, bank enables and NL status back out.
interface cb_dina_map_if;
   import cb_dina_map_pkg::*;

   logic [CB_DINA_SEL_DW-1:0] CB_dina_sel;
   logic                      l_k_0;
   lane_vec_t                 C_dout;
   logic                      nl_start;
   word_t                     xk_new;
   word_t                     yk_new;
   word_t                     xita_new;
   word_t                     lkx_new;
   word_t                     lky_new;
   bank_vec_t                 CB_dina;
   logic [L-1:0]              CB_wea;
   logic                      nl_busy;
   logic [1:0]                nl_step;
   logic                      nl_done;
   logic                      sel_conflict;

   modport master (
      output CB_dina_sel, l_k_0, C_dout, nl_start,
             xk_new, yk_new, xita_new, lkx_new, lky_new,
      input  CB_dina, CB_wea, nl_busy, nl_step, nl_done, sel_conflict
   );

   modport slave (
      input  CB_dina_sel, l_k_0, C_dout, nl_start,
             xk_new, yk_new, xita_new, lkx_new, lky_new,
      output CB_dina, CB_wea, nl_busy, nl_step, nl_done, sel_conflict
   );

endinterface

// File: rtl/cb_nl_wb_fsm.sv
// NL write-back sequencer: latches the five NL results and lk on an accepted start,
// then walks W_X/W_Y/W_T; outputs are decoded from state and registered by the parent.
module cb_nl_wb_fsm
   import cb_dina_map_pkg::*;
(
   input  logic         clk,
   input  logic         sys_rst,
   input  logic         i_nl_start,
   input  logic         i_l_k_0,
   input  nl_vals_t     i_vals,
   output logic         o_hold,
   output logic         o_busy,
   output bank_vec_t    o_dat,
   output logic [L-1:0] o_wea,
   output nl_step_e     o_step,
   output logic         o_done
);

   nl_state_e r_state;
   nl_state_e w_next;
   nl_vals_t  r_vals;
   logic      r_lk;
   logic      r_drain;
   logic      w_accept;

   // r_drain covers the cycle the registered W_T word is on the port, so a start
   // seen alongside nl_done is refused and the earliest restart follows it.
   assign w_accept = (r_state == NL_IDLE) && !r_drain && i_nl_start;
   assign o_hold   = w_accept || (r_state != NL_IDLE) || r_drain;

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         r_state <= NL_IDLE;
         r_drain <= 1'b0;
         r_vals  <= '0;
         r_lk    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_drain <= (r_state == NL_W_T);
         if (w_accept) begin
            r_vals <= i_vals;
            r_lk   <= i_l_k_0;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      o_busy = 1'b0;
      o_dat  = '0;
      o_wea  = '0;
      o_step = NL_STEP_X;
      o_done = 1'b0;
      case (r_state)
         NL_IDLE: begin
            if (w_accept) w_next = NL_W_X;
         end
         NL_W_X: begin
            w_next   = NL_W_Y;
            o_busy   = 1'b1;
            o_dat[0] = r_vals.xk;
            o_wea    = 4'b0001;
         end
         NL_W_Y: begin
            w_next   = NL_W_T;
            o_busy   = 1'b1;
            o_step   = NL_STEP_Y;
            o_dat[1] = r_vals.yk;
            if (r_lk) begin
               o_dat[0] = r_vals.lkx;
               o_wea    = 4'b0011;
            end else begin
               o_dat[2] = r_vals.lkx;
               o_wea    = 4'b0110;
            end
         end
         NL_W_T: begin
            w_next   = NL_IDLE;
            o_busy   = 1'b1;
            o_step   = NL_STEP_T;
            o_done   = 1'b1;
            o_dat[2] = r_vals.xita;
            if (r_lk) begin
               o_dat[1] = r_vals.lky;
               o_wea    = 4'b0110;
            end else begin
               o_dat[3] = r_vals.lky;
               o_wea    = 4'b1100;
            end
         end
         default: w_next = NL_IDLE;
      endcase
   end

endmodule

// File: rtl/cb_dina_map.sv
// CB port-A write mapper: C lanes or NL results onto banks with per-bank enables.
// Select/lanes sampled at one edge appear on CB_dina/CB_wea after the next; NL owns the port.
module cb_dina_map
   import cb_dina_map_pkg::*;
(
   input logic          clk,
   input logic          sys_rst,
   cb_dina_map_if.slave bus
);

   logic [2:0]   w_src;
   cbd_dir_e     w_dir;
   logic         w_c_req;
   logic         w_nl_hold;
   logic         w_nl_busy;
   bank_vec_t    w_nl_dat;
   logic [L-1:0] w_nl_wea;
   nl_step_e     w_nl_step;
   logic         w_nl_done;
   nl_vals_t     w_nl_vals;

   logic         r_c_vld;
   logic         r_conf_pend;
   cbd_dir_e     r_dir;
   logic         r_lk0;
   lane_vec_t    r_lanes;

   bank_vec_t    w_c_dat;
   logic [L-1:0] w_c_wea;
   bank_vec_t    w_dat;
   logic [L-1:0] w_wea;

   assign w_src   = sel_src(bus.CB_dina_sel);
   assign w_dir   = sel_dir(bus.CB_dina_sel);
   assign w_c_req = (w_src == CBd_C) && (w_dir != DIR_IDLE);

   assign w_nl_vals = '{xk:   bus.xk_new,
                        yk:   bus.yk_new,
                        xita: bus.xita_new,
                        lkx:  bus.lkx_new,
                        lky:  bus.lky_new};

   cb_nl_wb_fsm u_nl_fsm (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .i_nl_start (bus.nl_start),
      .i_l_k_0    (bus.l_k_0),
      .i_vals     (w_nl_vals),
      .o_hold     (w_nl_hold),
      .o_busy     (w_nl_busy),
      .o_dat      (w_nl_dat),
      .o_wea      (w_nl_wea),
      .o_step     (w_nl_step),
      .o_done     (w_nl_done)
   );

   // A C request is dropped at sampling time whenever NL holds the port, so the
   // two paths never contend for the same output slot.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         r_c_vld     <= 1'b0;
         r_conf_pend <= 1'b0;
         r_dir       <= DIR_IDLE;
         r_lk0       <= 1'b0;
         r_lanes     <= '0;
      end else begin
         r_c_vld     <= w_c_req && !w_nl_hold;
         r_conf_pend <= w_c_req && w_nl_hold;
         r_dir       <= w_dir;
         r_lk0       <= bus.l_k_0;
         r_lanes     <= bus.C_dout;
      end
   end

   always_comb begin
      w_c_dat = '0;
      w_c_wea = '0;
      if (r_c_vld) begin
         case (r_dir)
            DIR_POS: begin
               for (int i = 0; i < L; i++) w_c_dat[i] = r_lanes[i];
               w_c_wea = '1;
            end
            DIR_NEG: begin
               for (int i = 0; i < L; i++) w_c_dat[L-1-i] = r_lanes[i];
               w_c_wea = '1;
            end
            DIR_NEW: begin
               if (r_lk0) begin
                  w_c_dat[0] = r_lanes[0];
                  w_c_dat[1] = r_lanes[1];
                  w_c_wea    = 4'b0011;
               end else begin
                  w_c_dat[2] = r_lanes[0];
                  w_c_dat[3] = r_lanes[1];
                  w_c_wea    = 4'b1100;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_dat = w_c_dat;
      w_wea = w_c_wea;
      if (w_nl_busy) begin
         w_dat = w_nl_dat;
         w_wea = w_nl_wea;
      end
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         bus.CB_dina      <= '0;
         bus.CB_wea       <= '0;
         bus.nl_busy      <= 1'b0;
         bus.nl_step      <= 2'd0;
         bus.nl_done      <= 1'b0;
         bus.sel_conflict <= 1'b0;
      end else begin
         bus.CB_dina      <= w_dat;
         bus.CB_wea       <= w_wea;
         bus.nl_busy      <= w_nl_busy;
         bus.nl_step      <= w_nl_step;
         bus.nl_done      <= w_nl_done;
         bus.sel_conflict <= bus.sel_conflict | r_conf_pend;
      end
   end

endmodule

// File: doc/cb_dina_map.md
# cb_dina_map

Write-side lane-to-bank mapper for covariance buffer (CB) port A: the counterpart of the CB port-A read mapper. Takes systolic-array result lanes (C path) or nonlinear-unit state updates (NL path) and produces the registered `CB_dina` word plus per-bank write enables `CB_wea`. It applies the same forward, reverse and new-landmark bank mappings as the read side, so written data reads back in identical order. It sits between the RSA output / NL unit and the CB port-A write interface; the address generator drives addresses in parallel.

## Interface
- `X`, 4: RSA rows / C lanes
- `L`, 4: CB banks (mapping defined for L=4)
- `RSA_DW`, 32: word width, signed
- `CB_DINA_SEL_DW`, 5: select width
- `clk`  in  1: clock
- `sys_rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `CB_dina_sel`  in  CB_DINA_SEL_DW: [4:2] source (000 IDLE, 001 C, 111 NL); [1:0] direction (00 IDLE, 01 POS, 10 NEG, 11 NEW)
- `l_k_0`  in  1: landmark index LSB; 1 selects banks 0/1, 0 selects banks 2/3
- `C_dout`  in  X*RSA_DW: RSA result lanes
- `nl_start`  in  1: one-cycle pulse that launches an NL write-back
- `xk_new`, `yk_new`, `xita_new`, `lkx_new`, `lky_new`  in  RSA_DW each: NL results, sampled on `nl_start`
- `CB_dina`  out  L*RSA_DW: write data
- `CB_wea`  out  L: per-bank write enable
- `nl_busy`  out  1: NL sequence in progress
- `nl_step`  out  2: NL row being written (0 = x row, 1 = y row, 2 = theta row)
- `nl_done`  out  1: one-cycle pulse on the last NL write
- `sel_conflict`  out  1: sticky flag, set when C mode is requested while NL is busy

## Operation
- **C path**, active when source = 001 and the NL FSM is IDLE:
  - POS: lane i to bank i, `CB_wea`=1111.
  - NEG: lane i to bank L-1-i, `CB_wea`=1111.
  - NEW, `l_k_0`=1: lanes 0,1 to banks 0,1, `CB_wea`=0011.
  - NEW, `l_k_0`=0: lanes 0,1 to banks 2,3, `CB_wea`=1100.
  - Unwritten banks carry data 0.
  - DIR IDLE: data 0, `CB_wea`=0.
- **NL FSM** states: IDLE, W_X, W_Y, W_T.
  - IDLE to W_X on `nl_start`. Latch all five values and `l_k_0` (call it `lk`).
  - W_X: bank0 = xk, `CB_wea`=0001, `nl_step`=0.
  - W_Y: bank1 = yk; lkx to bank0 if `lk`=1, else bank2; `CB_wea`=0011 or 0110; `nl_step`=1.
  - W_T: bank2 = xita; lky to bank1 if `lk`=1, else bank3; `CB_wea`=0110 or 1100; `nl_step`=2; `nl_done`=1; next state IDLE.
  - `nl_busy`=1 in W_X, W_Y and W_T.
- `nl_start` while busy is ignored; latched values are unchanged.
- NL runs regardless of the `CB_dina_sel` source bits. Source 111 with `nl_start` low writes nothing.
- **Priority:** an active NL state owns the port. C-mode requests during NL are dropped, and `sel_conflict` is set. It clears only on reset.
- Source codes other than 001 and 111: data 0, `CB_wea`=0.
- Data is passed bit-exact with no arithmetic. Signed words are not sign-extended or truncated.

## Timing
- All outputs are registered.
- C path latency: 1 cycle, from `CB_dina_sel`/`C_dout` sampled at edge n to `CB_dina`/`CB_wea` valid after edge n+1.
- NL path: `nl_start` sampled at edge n gives W_X outputs after edge n+1, W_Y after n+2, W_T after n+3. `nl_busy` deasserts after edge n+4.
- Back-to-back: an `nl_start` in the W_T cycle is ignored. The earliest accepted restart is the cycle after `nl_done`.
- Reset: all outputs 0 and FSM to IDLE on the next edge, including mid-sequence. A partial NL write is abandoned and `nl_done` is not pulsed.
- `l_k_0` changing during NL has no effect, since `lk` is latched. In C mode, `l_k_0` is sampled in the same cycle as the data.

## Structure
- Shared package holds:
  - source codes: CBd_IDLE=000, CBd_C=001, CBd_NL=111
  - direction codes: DIR_IDLE, DIR_POS, DIR_NEG, DIR_NEW
  - NL state encoding
  - NL step codes
  - These are reused by the read mapper and the address generator.
- One natural sub-module: `cb_nl_wb_fsm`, which contains the NL FSM, the value latches, and the `nl_step`/`nl_done` generation. The top level holds the C mapping and the output mux/registers.

## Test plan
- Sel=001_01, `C_dout` lanes {4,3,2,1} (lane3..lane0) → next cycle `CB_dina`={4,3,2,1}, `CB_wea`=1111. Sel=001_10 → {1,2,3,4}, `CB_wea`=1111.
- Sel=001_11 with lanes 0,1 = 0x11,0x22: `l_k_0`=1 → banks0,1 = 0x11,0x22, `CB_wea`=0011. `l_k_0`=0 → banks2,3 = 0x11,0x22, `CB_wea`=1100, other banks 0.
- `nl_start`, `l_k_0`=1, xk=10, yk=20, xita=30, lkx=40, lky=50 → three cycles:
  - bank0=10, `CB_wea`=0001
  - bank1=20, bank0=40, `CB_wea`=0011
  - bank2=30, bank1=50, `CB_wea`=0110, `nl_done`=1
- Same with `l_k_0`=0, toggling `l_k_0` mid-sequence → cycle 2: bank1=20, bank2=40, `CB_wea`=0110; cycle 3: bank2=30, bank3=50, `CB_wea`=1100.
- Sel=001_01 asserted during NL W_Y → NL output unaffected, `sel_conflict`=1 and stays 1. Second `nl_start` in W_T is ignored.
- `sys_rst` in W_Y → next cycle all outputs 0, `nl_busy`=0, no `nl_done`. A subsequent `nl_start` runs a full clean sequence.
